alu_serial_ctrl: RTL and testbench
==================================

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (>= 4).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a, b  input  WIDTH  operands, latched on accepted start.
REQ-007 alu_ctl  input  4  {ainvert, bnegate, sel[1:0]}: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; all other codes illegal.
REQ-008 s_a, s_b, s_cin, s_ainvert, s_bnegate, s_less  output  1 each  drive to external 1-bit ALU slice.
REQ-009 s_op  output  3  slice select: 000 AND, 001 OR, 010 SUM, 011 LESS.
REQ-010 s_result, s_cout  input  1 each  combinational slice outputs, same cycle.
REQ-011 result  output  WIDTH  final result, held until next accepted start.
REQ-012 zero, overflow, carry_out, err  output  1 each  status, held with result.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse; result/status valid from this cycle.

Function
REQ-015 States IDLE, RUN, SLT_FIX, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-016 IDLE, start=1, legal alu_ctl: latch a, b, alu_ctl, clear bit index and result shift register, go to RUN.
REQ-017 IDLE, start=1, illegal alu_ctl: result=0, err=1, zero/overflow/carry_out=0, go to DONE (done 2nd cycle after start sampled).
REQ-018 start with busy=1 is ignored with no effect on the operation in progress.
REQ-019 RUN lasts exactly WIDTH cycles; in cycle i (i=0..WIDTH-1) s_a=a_lat[i], s_b=b_lat[i], s_ainvert/s_bnegate from latched alu_ctl.
REQ-020 s_op in RUN: AND->000, OR->001, ADD/SUB/SLT->010, NOR->000 (ainvert=bnegate=1).
REQ-021 s_cin: cycle 0 = bnegate; cycle i>0 = s_cout registered at end of cycle i-1.
REQ-022 s_less driven 0 in all states; SLT resolved in SLT_FIX.
REQ-023 Each RUN cycle shifts s_result into result bit i (LSB first); no partial result visible on result before done.
REQ-024 At last RUN cycle: carry_out <= s_cout; overflow <= s_cout XOR carry into MSB (registered s_cin at i=WIDTH-1), for ADD/SUB/SLT; overflow=0, carry_out=0 for logic ops.
REQ-025 After RUN: SLT -> SLT_FIX; others -> DONE.
REQ-026 SLT_FIX (one cycle): result <= {WIDTH-1 zeros, set}, set = MSB of difference XOR overflow; overflow and carry_out reported 0 for SLT.
REQ-027 zero = (final result == 0), updated with result.
REQ-028 Latency start-sampled to done: WIDTH+1 cycles (logic/ADD/SUB), WIDTH+2 (SLT).
REQ-029 In IDLE and DONE all slice drive outputs are 0.
REQ-030 err cleared on next accepted legal start.

Reset
REQ-031 reset=1 at a rising edge: state IDLE; result, zero, overflow, carry_out, err, busy, done, all slice outputs and internal carry/index = 0.
REQ-032 reset mid-RUN or SLT_FIX aborts the operation; no done pulse; next start after reset behaves as from power-up.
REQ-033 reset has priority over start in the same cycle.

Verification
REQ-034 ADD a=5, b=3, WIDTH=32 -> done at start+33, result=0x00000008, zero=0, overflow=0, carry_out=0.
REQ-035 ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1; SUB a=3, b=5 -> result=0xFFFFFFFD, overflow=0, carry_out=0.
REQ-036 SLT a=0x80000000, b=1 (overflowing subtract) -> done at start+34, result=1; SLT a=5, b=5 -> result=0, zero=1.
REQ-037 NOR a=0, b=0 -> 0xFFFFFFFF; AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000; bench models slice behaviourally and checks s_cin chain per cycle.
REQ-038 start pulsed again at cycle 10 of RUN -> ignored, original result unchanged; reset at cycle 15 -> busy=0 next cycle, no done.
REQ-039 alu_ctl=0101 -> err=1, result=0, done at start+2; next legal ADD clears err.

Source files
------------

// File: rtl/alu_serial_ctrl_if.sv
// Handshake and slice bus for alu_serial_ctrl.
//   start/a/b/alu_ctl    : operation request and operands (master -> slave)
//   s_a..s_less, s_op    : drive to the external 1-bit ALU slice (slave -> master)
//   s_result, s_cout     : combinational slice outputs (master -> slave)
//   result, zero, overflow, carry_out, err : final result and status
//   busy, done           : controller activity and one-cycle completion pulse
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctl;

  logic             s_a;
  logic             s_b;
  logic             s_cin;
  logic             s_ainvert;
  logic             s_bnegate;
  logic             s_less;
  logic [2:0]       s_op;
  logic             s_result;
  logic             s_cout;

  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic             err;
  logic             busy;
  logic             done;

  modport slave (
    input  start, a, b, alu_ctl, s_result, s_cout,
    output s_a, s_b, s_cin, s_ainvert, s_bnegate, s_less, s_op,
    output result, zero, overflow, carry_out, err, busy, done
  );

  modport master (
    output start, a, b, alu_ctl, s_result, s_cout,
    input  s_a, s_b, s_cin, s_ainvert, s_bnegate, s_less, s_op,
    input  result, zero, overflow, carry_out, err, busy, done
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller. Walks an external 1-bit ALU slice LSB first over
// WIDTH cycles, chaining the slice carry, and assembles the WIDTH-bit result.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : alu_serial_ctrl_if.slave (request, slice drive/return, result/status)
// alu_ctl = {ainvert, bnegate, sel[1:0]}: 0000 AND, 0001 OR, 0010 ADD,
// 0110 SUB, 0111 SLT, 1100 NOR; any other code completes with err=1.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  alu_serial_ctrl_if.slave bus
);

  localparam int            IW   = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SLT_FIX = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_lat, b_lat, shreg, full;
  logic [3:0]       ctl_lat;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             ovf_tmp;
  logic             legal, accept, last, arith, is_slt, set;

  always_comb begin
    legal = 1'b0;
    case (bus.alu_ctl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == RUN) && (idx == LAST);
  assign arith  = ctl_lat[1];
  assign is_slt = (ctl_lat == 4'b0111);
  // Result as it stands once the final slice bit is shifted in.
  assign full   = {bus.s_result, shreg[WIDTH-2:0]};
  // Signed less-than: sign of the difference corrected by overflow.
  assign set    = shreg[WIDTH-1] ^ ovf_tmp;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.s_a       = 1'b0;
    bus.s_b       = 1'b0;
    bus.s_cin     = 1'b0;
    bus.s_ainvert = 1'b0;
    bus.s_bnegate = 1'b0;
    bus.s_less    = 1'b0;
    bus.s_op      = 3'b000;
    case (state)
      IDLE: begin
        // An illegal code spends one cycle in SLT_FIX so its done pulse
        // lands two cycles after acceptance.
        if (bus.start) state_nx = legal ? RUN : SLT_FIX;
      end
      RUN: begin
        bus.s_a       = a_lat[idx];
        bus.s_b       = b_lat[idx];
        bus.s_cin     = carry;
        bus.s_ainvert = ctl_lat[3];
        bus.s_bnegate = ctl_lat[2];
        // ADD/SUB/SLT all use the slice sum; SLT is settled afterwards.
        bus.s_op      = {1'b0, ctl_lat[1], ctl_lat[0] & ~ctl_lat[1]};
        if (last) state_nx = is_slt ? SLT_FIX : DONE;
      end
      SLT_FIX: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_lat         <= '0;
      b_lat         <= '0;
      ctl_lat       <= '0;
      shreg         <= '0;
      idx           <= '0;
      carry         <= 1'b0;
      ovf_tmp       <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (legal) begin
              a_lat   <= bus.a;
              b_lat   <= bus.b;
              ctl_lat <= bus.alu_ctl;
              shreg   <= '0;
              idx     <= '0;
              // Carry into bit 0 is the subtract +1.
              carry   <= bus.alu_ctl[2];
              bus.err <= 1'b0;
            end else begin
              bus.result    <= '0;
              bus.zero      <= 1'b0;
              bus.overflow  <= 1'b0;
              bus.carry_out <= 1'b0;
              bus.err       <= 1'b1;
            end
          end
        end
        RUN: begin
          shreg[idx] <= bus.s_result;
          carry      <= bus.s_cout;
          idx        <= idx + 1'b1;
          if (last) begin
            ovf_tmp <= arith & (bus.s_cout ^ carry);
            if (!is_slt) begin
              bus.result    <= full;
              bus.zero      <= (full == '0);
              bus.overflow  <= arith & (bus.s_cout ^ carry);
              bus.carry_out <= arith & bus.s_cout;
            end
          end
        end
        SLT_FIX: begin
          if (!bus.err) begin
            bus.result    <= {{(WIDTH-1){1'b0}}, set};
            bus.zero      <= ~set;
            bus.overflow  <= 1'b0;
            bus.carry_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl with a behavioural 1-bit slice.
module tb_alu_serial_ctrl;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         z, ov, co, er;
    int unsigned  lat;
    int unsigned  t0;
    logic [W-1:0] cin;
    bit           chk_cin;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_serial_ctrl_if #(.WIDTH(W)) bus();
  alu_serial_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Behavioural 1-bit ALU slice.
  always_comb begin
    logic aa, bb;
    aa = bus.s_a ^ bus.s_ainvert;
    bb = bus.s_b ^ bus.s_bnegate;
    bus.s_cout = (aa & bb) | (aa & bus.s_cin) | (bb & bus.s_cin);
    case (bus.s_op)
      3'b000:  bus.s_result = aa & bb;
      3'b001:  bus.s_result = aa | bb;
      3'b010:  bus.s_result = aa ^ bb ^ bus.s_cin;
      3'b011:  bus.s_result = bus.s_less;
      default: bus.s_result = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] ctl, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int unsigned t0);
    exp_t e;
    logic [W-1:0] aa, bb;
    logic [W:0]   s, u;
    longint       sr, lim;
    e.res = '0; e.z = 1'b0; e.ov = 1'b0; e.co = 1'b0; e.er = 1'b0;
    e.t0 = t0; e.lat = W + 1; e.chk_cin = 1'b1;
    lim = longint'(1) << (W - 1);
    // Carry into each bit of A + B + bnegate, for the slice carry chain.
    aa = ctl[3] ? ~a : a;
    bb = ctl[2] ? ~b : b;
    s = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ctl[2]};
    e.cin = s[W-1:0] ^ aa ^ bb;
    case (ctl)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~(a | b);
      4'b0010: begin
        e.res = a + b;
        u = {1'b0, a} + {1'b0, b};
        e.co = u[W];
        sr = longint'($signed(a)) + longint'($signed(b));
        e.ov = (sr >= lim) || (sr < -lim);
      end
      4'b0110: begin
        e.res = a - b;
        e.co = (a >= b);
        sr = longint'($signed(a)) - longint'($signed(b));
        e.ov = (sr >= lim) || (sr < -lim);
      end
      4'b0111: begin
        e.res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
        e.lat = W + 2;
      end
      default: begin
        e.er = 1'b1;
        e.lat = 2;
        e.chk_cin = 1'b0;
      end
    endcase
    e.z = (e.res == '0) && !e.er;
    return e;
  endfunction

  // Monitor: captures s_cin per RUN cycle of the head transaction, checks on done.
  initial begin : monitor
    logic [W-1:0] cin_obs;
    exp_t         e;
    int           rel;
    cin_obs = '0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        rel = int'(cyc) - int'(q[0].t0);
        if (rel >= 1 && rel <= W) cin_obs[rel-1] = bus.s_cin;
      end
      if (bus.done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = q.pop_front();
          check("result", 64'(bus.result), 64'(e.res));
          check("flags_z_ov_co_err", 64'({bus.zero, bus.overflow, bus.carry_out, bus.err}),
                64'({e.z, e.ov, e.co, e.er}));
          check("latency", 64'(cyc - e.t0), 64'(e.lat));
          if (e.chk_cin) check("cin_chain", 64'(cin_obs), 64'(e.cin));
        end
      end
    end
  end

  // Called at a negedge; leaves the caller at the following negedge.
  task automatic issue(input logic [3:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit expect_it);
    bus.start = 1'b1;
    bus.alu_ctl = ctl;
    bus.a = a;
    bus.b = b;
    if (expect_it) q.push_back(model(ctl, a, b, cyc));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.alu_ctl = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("timeout", 64'(q.size()) + 64'(bus.busy), 64'd0);
      q.delete();
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] legal_codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  logic [3:0] bad_codes   [6] = '{4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1010, 4'b1111};

  initial begin : stim
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.alu_ctl = '0;
    repeat (3) @(negedge clk);
    check("reset_state",
          64'({bus.result, bus.zero, bus.overflow, bus.carry_out, bus.err, bus.busy, bus.done,
               bus.s_a, bus.s_b, bus.s_cin, bus.s_ainvert, bus.s_bnegate, bus.s_less, bus.s_op}),
          64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(4'b0010, 32'd5, 32'd3, 1'b1);                 wait_idle();
    issue(4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b1);         wait_idle();
    issue(4'b0110, 32'd3, 32'd5, 1'b1);                 wait_idle();
    issue(4'b0111, 32'h8000_0000, 32'd1, 1'b1);         wait_idle();
    issue(4'b0111, 32'd5, 32'd5, 1'b1);                 wait_idle();
    issue(4'b1100, 32'd0, 32'd0, 1'b1);                 wait_idle();
    issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1); wait_idle();
    issue(4'b0101, 32'd7, 32'd9, 1'b1);                 wait_idle();
    issue(4'b0010, 32'd1, 32'd1, 1'b1);                 wait_idle();

    // Start pulsed mid-operation must not disturb the running ADD.
    issue(4'b0010, 32'h1234_5678, 32'h0101_0101, 1'b1);
    repeat (9) @(negedge clk);
    issue(4'b0110, 32'hDEAD_BEEF, 32'h1, 1'b0);
    wait_idle();

    // Reset mid-RUN aborts: no done, status cleared.
    issue(4'b0110, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_state", 64'({bus.result, bus.busy, bus.done, bus.err}), 64'd0);
    reset = 1'b0;
    repeat (W + 8) @(negedge clk);

    for (int k = 0; k < 60; k++) begin
      logic [3:0]   ctl;
      logic [W-1:0] x, y;
      ctl = legal_codes[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) ctl = bad_codes[$urandom_range(0, 5)];
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      if ($urandom_range(0, 5) == 0) x = {1'b1, 31'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) y = '0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(ctl, x, y, 1'b1);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
